// File: rtl/cert_chain_verifier_pkg.sv
// Shared definitions for the certificate chain verifier: FSM encoding,
// per-slot chain lengths, reference certificate contents, chunk derivation.
package cert_chain_verifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMPARE,
    ST_RESULT
  } state_t;

  localparam int DEF_NUM_SLOTS = 3;

  // Chain length per slot; 0 marks an empty (unprovisioned) slot.
  function automatic int unsigned chain_len(input int unsigned slot);
    case (slot)
      0:       return 6;
      1:       return 4;
      2:       return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned num_chunks(input int unsigned payload_w, input int unsigned chunk_w);
    return payload_w / chunk_w;
  endfunction

  // Reference chunk content for (slot, 0-based cert index, chunk number).
  function automatic logic [31:0] ref_word(input int unsigned slot, input int unsigned idx,
                                           input int unsigned chunk);
    logic [31:0] s, i, c;
    s = slot;
    i = idx;
    c = chunk;
    return {8'hA5 ^ s[7:0], i[7:0], c[7:0], 8'h3C};
  endfunction

endpackage

// File: rtl/cert_chain_verifier_if.sv
// Certificate delivery handshake: the host (master) offers a certificate,
// the verifier (slave) accepts it when ready.
interface cert_chain_verifier_if #(
  parameter int PAYLOAD_W = 256,
  parameter int CNT_W     = 8
);
  logic                 Payload_valid;
  logic                 Payload_ready;
  logic [PAYLOAD_W-1:0] Payload_in;
  logic [CNT_W-1:0]     Counter_in;

  modport master (output Payload_valid, Payload_in, Counter_in, input Payload_ready);
  modport slave  (input Payload_valid, Payload_in, Counter_in, output Payload_ready);
endinterface

// File: rtl/cert_chain_verifier_rom.sv
// cert_ref_rom: synchronous reference store, address {slot, index-1, chunk},
// one cycle read latency. Kept as its own block so an OTP/RAM wrapper can
// replace it without touching the FSM.
module cert_ref_rom
  import cert_chain_verifier_pkg::*;
#(
  parameter int SLOT_W  = 2,
  parameter int IDX_W   = 3,
  parameter int CHK_W   = 3,
  parameter int CHUNK_W = 32
) (
  input  logic                          clk,
  input  logic [SLOT_W+IDX_W+CHK_W-1:0] addr,
  output logic [CHUNK_W-1:0]            data
);
  localparam int AW = SLOT_W + IDX_W + CHK_W;

  // Registered read of the reference chunk.
  always_ff @(posedge clk)
    data <= CHUNK_W'(ref_word(32'(addr[AW-1 -: SLOT_W]), 32'(addr[CHK_W +: IDX_W]),
                              32'(addr[CHK_W-1:0])));
endmodule

// File: rtl/cert_chain_verifier.sv
// cert_chain_verifier: walks a certificate chain for one slot, checking
// in-order indices and comparing each payload against the reference store
// one CHUNK_W slice per cycle (constant latency, no early exit).
// Optional feature macro: CERT_CHAIN_TIMEOUT_EN (WAIT-state timeout).
module cert_chain_verifier
  import cert_chain_verifier_pkg::*;
#(
  parameter int PAYLOAD_W      = 256,
  parameter int CHUNK_W        = 32,
  parameter int NUM_SLOTS      = DEF_NUM_SLOTS,
  parameter int MAX_CERTS      = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         Reset_n,
  input  logic                         Start,
  input  logic                         Abort,
  input  logic [$clog2(NUM_SLOTS)-1:0] Slot,
  cert_chain_verifier_if.slave         cert,
  output logic                         Busy,
  output logic                         Valid_Certificate,
  output logic                         Error_Invalid_Certificate,
  output logic                         Error_Out_Of_Order,
  output logic                         Error_Invalid_Slot,
  output logic                         Error_Timeout,
  output logic                         Chain_done,
  output logic [CNT_W-1:0]             Cert_index
);
  localparam int NUM_CHUNKS = num_chunks(PAYLOAD_W, CHUNK_W);
  localparam int CHK_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_W      = (MAX_CERTS > 1) ? $clog2(MAX_CERTS) : 1;
  localparam int SLOT_W     = $clog2(NUM_SLOTS);

  state_t               state;
  logic [SLOT_W-1:0]    slot_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic                 mismatch;
  logic [CHK_W-1:0]     chunk;
  logic [CHK_W-1:0]     rom_chunk;
  logic [IDX_W-1:0]     rom_idx;
  logic [CHUNK_W-1:0]   rom_data;
  logic                 handshake;
  logic                 slot_ok;
  logic                 last_cert;

  assign handshake = (state == ST_WAIT) && cert.Payload_valid && cert.Payload_ready;
  assign slot_ok   = (32'(Slot) < 32'(NUM_SLOTS)) && (chain_len(32'(Slot)) != 0);
  assign last_cert = (Cert_index == CNT_W'(chain_len(32'(slot_q))));

  // WAIT presents chunk 0 so its data is ready on the first COMPARE cycle;
  // COMPARE prefetches the next chunk while checking the current one.
  assign rom_chunk = (state == ST_COMPARE) ? chunk + CHK_W'(1) : '0;
  assign rom_idx   = IDX_W'(Cert_index - CNT_W'(1));

  cert_ref_rom #(
    .SLOT_W (SLOT_W),
    .IDX_W  (IDX_W),
    .CHK_W  (CHK_W),
    .CHUNK_W(CHUNK_W)
  ) u_rom (
    .clk (clk),
    .addr({slot_q, rom_idx, rom_chunk}),
    .data(rom_data)
  );

`ifdef CERT_CHAIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign Error_Timeout = 1'b0;
`endif

  // Control FSM with registered handshake, status pulses and index.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state                     <= ST_IDLE;
      slot_q                    <= '0;
      payload_q                 <= '0;
      mismatch                  <= 1'b0;
      chunk                     <= '0;
      Cert_index                <= '0;
      Busy                      <= 1'b0;
      cert.Payload_ready        <= 1'b0;
      Valid_Certificate         <= 1'b0;
      Error_Invalid_Certificate <= 1'b0;
      Error_Out_Of_Order        <= 1'b0;
      Error_Invalid_Slot        <= 1'b0;
      Chain_done                <= 1'b0;
`ifdef CERT_CHAIN_TIMEOUT_EN
      to_cnt                    <= '0;
      Error_Timeout             <= 1'b0;
`endif
    end else begin
      Valid_Certificate         <= 1'b0;
      Error_Invalid_Certificate <= 1'b0;
      Error_Out_Of_Order        <= 1'b0;
      Error_Invalid_Slot        <= 1'b0;
      Chain_done                <= 1'b0;
`ifdef CERT_CHAIN_TIMEOUT_EN
      Error_Timeout             <= 1'b0;
`endif
      if (Abort) begin
        state              <= ST_IDLE;
        Cert_index         <= '0;
        Busy               <= 1'b0;
        cert.Payload_ready <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (Start) begin
            if (!slot_ok) begin
              Error_Invalid_Slot <= 1'b1;
            end else begin
              slot_q             <= Slot;
              Cert_index         <= CNT_W'(1);
              state              <= ST_WAIT;
              Busy               <= 1'b1;
              cert.Payload_ready <= 1'b1;
`ifdef CERT_CHAIN_TIMEOUT_EN
              to_cnt             <= '0;
`endif
            end
          end
          ST_WAIT: begin
            if (handshake) begin
              payload_q          <= cert.Payload_in;
              cert.Payload_ready <= 1'b0;
              if (cert.Counter_in != Cert_index) begin
                Error_Out_Of_Order <= 1'b1;
                state              <= ST_IDLE;
                Busy               <= 1'b0;
              end else begin
                mismatch <= 1'b0;
                chunk    <= '0;
                state    <= ST_COMPARE;
              end
            end
`ifdef CERT_CHAIN_TIMEOUT_EN
            else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
              Error_Timeout      <= 1'b1;
              state              <= ST_IDLE;
              Busy               <= 1'b0;
              cert.Payload_ready <= 1'b0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
`endif
          end
          ST_COMPARE: begin
            mismatch <= mismatch | (rom_data != payload_q[int'(chunk)*CHUNK_W +: CHUNK_W]);
            chunk    <= chunk + CHK_W'(1);
            if (chunk == CHK_W'(NUM_CHUNKS - 1)) state <= ST_RESULT;
          end
          ST_RESULT: begin
            if (mismatch) begin
              Error_Invalid_Certificate <= 1'b1;
              state                     <= ST_IDLE;
              Busy                      <= 1'b0;
            end else if (last_cert) begin
              Valid_Certificate <= 1'b1;
              Chain_done        <= 1'b1;
              state             <= ST_IDLE;
              Busy              <= 1'b0;
            end else begin
              Valid_Certificate  <= 1'b1;
              if (Cert_index < CNT_W'(MAX_CERTS)) Cert_index <= Cert_index + CNT_W'(1);
              state              <= ST_WAIT;
              cert.Payload_ready <= 1'b1;
`ifdef CERT_CHAIN_TIMEOUT_EN
              to_cnt             <= '0;
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cert_chain_verifier.sv
// Directed bench for cert_chain_verifier: table of chain transactions with
// hand-computed results, plus sequences for reset, abort, busy-start, timeout.
module tb_cert_chain_verifier;
  localparam int PW  = 256;
  localparam int CW  = 32;
  localparam int NCH = PW / CW;
  localparam int CNT_W = 8;
`ifdef CERT_CHAIN_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Start = 1'b0;
  logic Abort = 1'b0;
  logic [1:0] Slot = '0;
  logic Busy, vc, inv, ooo, islot, tmo, done;
  logic [CNT_W-1:0] Cert_index;

  cert_chain_verifier_if #(.PAYLOAD_W(PW), .CNT_W(CNT_W)) bus ();

  cert_chain_verifier #(
    .PAYLOAD_W(PW), .CHUNK_W(CW), .NUM_SLOTS(3), .MAX_CERTS(8), .CNT_W(CNT_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort), .Slot(Slot),
    .cert(bus), .Busy(Busy), .Valid_Certificate(vc),
    .Error_Invalid_Certificate(inv), .Error_Out_Of_Order(ooo),
    .Error_Invalid_Slot(islot), .Error_Timeout(tmo), .Chain_done(done),
    .Cert_index(Cert_index)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit start; int slot; int cnt; int flip;
    int exp_code; int exp_lat; bit exp_done; bit exp_busy; int exp_idx;
  } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Independent statement of the provisioned reference certificates.
  function automatic logic [PW-1:0] ref_cert(input int slot, input int cnt);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < NCH; c++)
      r[c*CW +: CW] = {8'hA5 ^ 8'(slot), 8'(cnt - 1), 8'(c), 8'h3C};
    return r;
  endfunction

  // 0 none, 1 valid, 2 bad cert, 3 out of order, 4 bad slot, 5 timeout, 9 several
  function automatic int pulse_code();
    int n;
    n = int'(vc) + int'(inv) + int'(ooo) + int'(islot) + int'(tmo);
    if (n == 0) return 0;
    if (n > 1) return 9;
    if (vc) return 1;
    if (inv) return 2;
    if (ooo) return 3;
    if (islot) return 4;
    return 5;
  endfunction

  task automatic observe(output int code, output int lat, output bit d);
    code = 0; lat = 0; d = 0;
    for (int n = 1; n <= 14 && code == 0; n++) begin
      code = pulse_code();
      if (code != 0) begin lat = n; d = done; end
      else tick();
    end
  endtask

  task automatic send(input logic [PW-1:0] p, input int cnt);
    int w;
    w = 0;
    while (!bus.Payload_ready && w < 5) begin tick(); w++; end
    if (!bus.Payload_ready) chk("ready_wait", 0, 1);
    bus.Payload_valid = 1'b1;
    bus.Payload_in    = p;
    bus.Counter_in    = CNT_W'(cnt);
    tick();
    bus.Payload_valid = 1'b0;
  endtask

  task automatic do_start(input int s);
    Start = 1'b1;
    Slot  = 2'(s);
    tick();
    Start = 1'b0;
  endtask

  initial begin
    int code, lat;
    bit d;
    bit seen;
    logic [PW-1:0] p;

    bus.Payload_valid = 1'b0;
    bus.Payload_in    = '0;
    bus.Counter_in    = '0;

    // start, slot, cnt, flip, code, lat, done, busy, idx
    for (int k = 1; k <= 6; k++)
      tbl.push_back('{k == 1, 0, k, -1, 1, 10, k == 6, k < 6, (k < 6) ? k + 1 : 6});
    tbl.push_back('{1, 1, 1, -1, 1, 10, 0, 1, 2});
    tbl.push_back('{0, 1, 2, 7*CW, 2, 10, 0, 0, 2});
    tbl.push_back('{1, 2, 1, -1, 1, 10, 0, 1, 2});
    tbl.push_back('{0, 2, 3, -1, 3, 1, 0, 0, 2});
    tbl.push_back('{1, 3, 0, -1, 4, 1, 0, 0, -1});
    for (int k = 1; k <= 4; k++)
      tbl.push_back('{k == 1, 1, k, -1, 1, 10, k == 4, k < 4, (k < 4) ? k + 1 : 4});
    for (int k = 1; k <= 5; k++)
      tbl.push_back('{k == 1, 2, k, -1, 1, 10, k == 5, k < 5, (k < 5) ? k + 1 : 5});

    // Reset state
    tick(); tick();
    chk("rst_busy", Busy, 0);
    chk("rst_ready", bus.Payload_ready, 0);
    chk("rst_pulses", pulse_code(), 0);
    chk("rst_done", done, 0);
    chk("rst_idx", Cert_index, 0);
    Reset_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      if (tbl[i].start) do_start(tbl[i].slot);
      if (tbl[i].cnt != 0) begin
        p = ref_cert(tbl[i].slot, tbl[i].cnt);
        if (tbl[i].flip >= 0) p[tbl[i].flip] = ~p[tbl[i].flip];
        send(p, tbl[i].cnt);
      end
      observe(code, lat, d);
      chk($sformatf("row%0d_code", i), code, tbl[i].exp_code);
      chk($sformatf("row%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("row%0d_done", i), d, tbl[i].exp_done);
      chk($sformatf("row%0d_busy", i), Busy, tbl[i].exp_busy);
      chk($sformatf("row%0d_ready", i), bus.Payload_ready, tbl[i].exp_busy);
      if (tbl[i].exp_idx >= 0) chk($sformatf("row%0d_idx", i), Cert_index, tbl[i].exp_idx);
      tick();
      chk($sformatf("row%0d_one_cycle", i), pulse_code() + int'(done), 0);
    end

    // Start while busy is ignored
    do_start(0);
    do_start(3);
    chk("busy_start_pulse", pulse_code(), 0);
    chk("busy_start_busy", Busy, 1);
    chk("busy_start_idx", Cert_index, 1);
    chk("busy_start_ready", bus.Payload_ready, 1);

    // Abort during RESULT: no pulse, IDLE, index cleared
    send(ref_cert(0, 1), 1);
    repeat (8) tick();
    chk("abort_pre_busy", Busy, 1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_pulse", pulse_code(), 0);
    chk("abort_busy", Busy, 0);
    chk("abort_idx", Cert_index, 0);
    chk("abort_ready", bus.Payload_ready, 0);
    tick();
    chk("abort_late_pulse", pulse_code(), 0);

    // Asynchronous reset in COMPARE
    do_start(1);
    send(ref_cert(1, 1), 1);
    tick(); tick();
    chk("arst_pre_busy", Busy, 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_idx", Cert_index, 0);
    chk("arst_ready", bus.Payload_ready, 0);
    chk("arst_pulses", pulse_code(), 0);
    tick();
    Reset_n = 1'b1;
    repeat (12) tick();
    chk("arst_after_busy", Busy, 0);
    chk("arst_after_pulses", pulse_code(), 0);

    // WAIT timeout behaviour
    do_start(2);
`ifdef CERT_CHAIN_TIMEOUT_EN
    seen = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (tmo) seen = 1;
    end
    chk("to_early", seen, 0);
    tick();
    chk("to_code", pulse_code(), 5);
    chk("to_busy", Busy, 0);
    tick();
    chk("to_one_cycle", tmo, 0);
`else
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!Busy || tmo) seen = 1;
    end
    chk("no_to_busy_hold", seen, 0);
    chk("no_to_ready", bus.Payload_ready, 1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("no_to_abort_busy", Busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
